// File: rtl/branch_predictor_if.sv
// Fetch/execute side signal bundle for branch_predictor.
// The pipeline drives through the master modport; the predictor uses slave.
// br_count/mp_count exist only when BP_STATS_EN is defined.
interface branch_predictor_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pc_f;
  logic            stall_d;
  logic            flush_d;
  logic            flush_e;
  logic [XLEN-1:0] next_pc;
  logic            pred_taken_f;
  logic            e_is_branch;
  logic            e_is_jump;
  logic            e_taken;
  logic [XLEN-1:0] e_target;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0]     br_count;
  logic [31:0]     mp_count;
`endif

  modport master (
    output pc_f, stall_d, flush_d, flush_e,
    output e_is_branch, e_is_jump, e_taken, e_target,
`ifdef BP_STATS_EN
    input  br_count, mp_count,
`endif
    input  next_pc, pred_taken_f, mispredict, redirect_pc
  );

  modport slave (
    input  pc_f, stall_d, flush_d, flush_e,
    input  e_is_branch, e_is_jump, e_taken, e_target,
`ifdef BP_STATS_EN
    output br_count, mp_count,
`endif
    output next_pc, pred_taken_f, mispredict, redirect_pc
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit bimodal counters for the 5-stage RV32 pipeline.
// Predicts from the F-stage PC, carries the prediction through D and E shadow
// registers and checks it against the outcome resolved in E.
// Optional macro BP_STATS_EN adds saturating branch/mispredict counters.
module branch_predictor #(
  parameter int         XLEN     = 32,
  parameter int         IDX_W    = 4,
  parameter logic [1:0] CTR_INIT = 2'b10
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bp
);
  localparam int              ENTRIES = 1 << IDX_W;
  localparam int              TAG_W   = XLEN - IDX_W - 2;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  // Table storage: valid/ctr need reset, tag/target/jmp do not.
  logic             tblValid  [ENTRIES];
  logic [1:0]       tblCtr    [ENTRIES];
  logic             tblJmp    [ENTRIES];
  logic [TAG_W-1:0] tblTag    [ENTRIES];
  logic [XLEN-1:0]  tblTarget [ENTRIES];

  // F-stage lookup
  logic [IDX_W-1:0] idxF;
  logic [TAG_W-1:0] tagF;
  logic             hitF;
  logic             predTakenF;
  logic [XLEN-1:0]  predTargetF;

  assign idxF        = bp.pc_f[IDX_W+1:2];
  assign tagF        = bp.pc_f[XLEN-1:IDX_W+2];
  assign hitF        = tblValid[idxF] && (tblTag[idxF] == tagF);
  assign predTakenF  = hitF && (tblJmp[idxF] || tblCtr[idxF][1]);
  assign predTargetF = tblTarget[idxF];

  // Shadow pipeline registers
  logic            vD, predD, vE, predE;
  logic [XLEN-1:0] pcD, tgtD, pcE, tgtE;

  // F->D shadow: flush beats stall, stall holds
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vD <= 1'b0; predD <= 1'b0; pcD <= '0; tgtD <= '0;
    end else if (bp.flush_d) begin
      vD <= 1'b0; predD <= 1'b0; pcD <= '0; tgtD <= '0;
    end else if (!bp.stall_d) begin
      vD <= 1'b1; predD <= predTakenF; pcD <= bp.pc_f; tgtD <= predTargetF;
    end
  end

  // D->E shadow: no stall, only flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vE <= 1'b0; predE <= 1'b0; pcE <= '0; tgtE <= '0;
    end else if (bp.flush_e) begin
      vE <= 1'b0; predE <= 1'b0; pcE <= '0; tgtE <= '0;
    end else begin
      vE <= vD; predE <= predD; pcE <= pcD; tgtE <= tgtD;
    end
  end

  // E-stage resolution
  logic [IDX_W-1:0] idxE;
  logic [TAG_W-1:0] tagE;
  logic             hitE, cfE, mispredictE;
  logic             allocE, updE, killE;
  logic [1:0]       ctrE, ctrNextE;

  assign idxE   = pcE[IDX_W+1:2];
  assign tagE   = pcE[XLEN-1:IDX_W+2];
  assign hitE   = tblValid[idxE] && (tblTag[idxE] == tagE);
  assign cfE    = vE && (bp.e_is_branch || bp.e_is_jump);
  assign allocE = cfE && !hitE && bp.e_taken;
  assign updE   = cfE && hitE;
  // A non-control-flow instruction that hits can only be an alias; drop it.
  assign killE  = vE && !cfE && hitE;
  assign ctrE   = tblCtr[idxE];

  // Saturating counter step toward the resolved direction
  always_comb begin
    ctrNextE = ctrE;
    if (bp.e_taken) begin
      if (ctrE != 2'b11) ctrNextE = ctrE + 2'd1;
    end else begin
      if (ctrE != 2'b00) ctrNextE = ctrE - 2'd1;
    end
  end

  // Wrong direction, wrong target, or a taken prediction on a non-CF instruction
  always_comb begin
    mispredictE = 1'b0;
    if (cfE) begin
      mispredictE = (predE != bp.e_taken) || (bp.e_taken && (tgtE != bp.e_target));
    end else if (vE) begin
      mispredictE = predE;
    end
  end

  assign bp.mispredict   = mispredictE;
  assign bp.redirect_pc  = (cfE && bp.e_taken) ? bp.e_target : (pcE + PC_STEP);
  assign bp.pred_taken_f = predTakenF;
  assign bp.next_pc      = mispredictE ? bp.redirect_pc
                         : predTakenF  ? predTargetF
                         : (bp.pc_f + PC_STEP);

  // Valid bits and counters: allocate, train, or invalidate aliases
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tblValid[i] <= 1'b0;
        tblCtr[i]   <= CTR_INIT;
      end
    end else if (allocE) begin
      tblValid[idxE] <= 1'b1;
      tblCtr[idxE]   <= CTR_INIT;
    end else if (updE) begin
      tblCtr[idxE]   <= ctrNextE;
    end else if (killE) begin
      tblValid[idxE] <= 1'b0;
    end
  end

  // Entry payload is rewritten on every taken control-flow resolution
  always_ff @(posedge clk) begin
    if (cfE && bp.e_taken) begin
      tblTag[idxE]    <= tagE;
      tblTarget[idxE] <= bp.e_target;
      tblJmp[idxE]    <= bp.e_is_jump;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] brCountReg, mpCountReg;

  // Saturating resolution and misprediction counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      brCountReg <= '0;
      mpCountReg <= '0;
    end else begin
      if (cfE && (brCountReg != 32'hFFFF_FFFF)) brCountReg <= brCountReg + 32'd1;
      if (mispredictE && (mpCountReg != 32'hFFFF_FFFF)) mpCountReg <= mpCountReg + 32'd1;
    end
  end

  assign bp.br_count = brCountReg;
  assign bp.mp_count = mpCountReg;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: expectations are queued as stimulus is
// applied and popped/compared at the falling edge of the same cycle.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  branch_predictor_if #(.XLEN(32)) bpIf ();

  branch_predictor #(.XLEN(32), .IDX_W(4), .CTR_INIT(2'b10)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bpIf)
  );

  localparam int SIG_PRED = 0, SIG_NEXT = 1, SIG_MP = 2, SIG_REDIR = 3, SIG_BR = 4, SIG_MPC = 5;
  localparam logic [31:0] F1 = 32'h0000_0204;
  localparam logic [31:0] F2 = 32'h0000_0208;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t sbQ[$];
  int   testsRun  = 0;
  int   failCount = 0;
  int   brExp     = 0;
  int   mpExp     = 0;

  function automatic logic [31:0] observe(int sig);
    logic [31:0] r;
    r = 32'hDEAD_BEEF;
    case (sig)
      SIG_PRED:  r = {31'b0, bpIf.pred_taken_f};
      SIG_NEXT:  r = bpIf.next_pc;
      SIG_MP:    r = {31'b0, bpIf.mispredict};
      SIG_REDIR: r = bpIf.redirect_pc;
`ifdef BP_STATS_EN
      SIG_BR:    r = bpIf.br_count;
      SIG_MPC:   r = bpIf.mp_count;
`endif
      default:   r = 32'hDEAD_BEEF;
    endcase
    return r;
  endfunction

  task automatic expectVal(input string n, input int sig, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.sig  = sig;
    e.val  = v;
    sbQ.push_back(e);
  endtask

  task automatic drainCheck();
    exp_t        e;
    logic [31:0] obs;
    while (sbQ.size() != 0) begin
      e   = sbQ.pop_front();
      obs = observe(e.sig);
      testsRun++;
      assert (obs === e.val)
      else begin
        failCount++;
        $error("FAIL %s: observed 0x%08h expected 0x%08h", e.name, obs, e.val);
      end
      $display("[TB] %s observed=0x%08h expected=0x%08h", e.name, obs, e.val);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    drainCheck();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic br, input logic jmp,
                       input logic tk, input logic [31:0] tgt);
    bpIf.pc_f        = pc;
    bpIf.e_is_branch = br;
    bpIf.e_is_jump   = jmp;
    bpIf.e_taken     = tk;
    bpIf.e_target    = tgt;
  endtask

  // Instruction at pc in F, two fillers behind it, resolved in E on the third cycle
  task automatic runBranch(input string n, input logic [31:0] pc, input logic br,
                           input logic jmp, input logic tk, input logic [31:0] tgt,
                           input logic expPred, input logic [31:0] expNext,
                           input logic expMp, input logic [31:0] expRedir);
    drive(pc, 1'b0, 1'b0, 1'b0, 32'h0);
    expectVal({n, ".pred"}, SIG_PRED, {31'b0, expPred});
    expectVal({n, ".next"}, SIG_NEXT, expNext);
    tick();
    drive(F1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(F2, br, jmp, tk, tgt);
    expectVal({n, ".mp"}, SIG_MP, {31'b0, expMp});
    expectVal({n, ".nextE"}, SIG_NEXT, expMp ? expRedir : (F2 + 32'd4));
    if (expMp) expectVal({n, ".redir"}, SIG_REDIR, expRedir);
    tick();
    if (br || jmp) brExp++;
    if (expMp) mpExp++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bpIf.stall_d = 1'b0;
    bpIf.flush_d = 1'b0;
    bpIf.flush_e = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    // 1: reset state
    expectVal("t1.rst.pred", SIG_PRED, 32'd0);
    expectVal("t1.rst.next", SIG_NEXT, 32'h4);
    expectVal("t1.rst.mp",   SIG_MP,   32'd0);
`ifdef BP_STATS_EN
    expectVal("t1.rst.br", SIG_BR,  32'd0);
    expectVal("t1.rst.mc", SIG_MPC, 32'd0);
`endif
    tick();
    rst = 1'b1;
    expectVal("t1.pred", SIG_PRED, 32'd0);
    expectVal("t1.next", SIG_NEXT, 32'h4);
    expectVal("t1.mp",   SIG_MP,   32'd0);
    tick();

    // 2: first encounter allocates; afterwards predicted taken
    runBranch("t2.first", 32'h10, 1, 0, 1, 32'h40, 0, 32'h14, 1, 32'h40);
    // 3: not-taken from ctr=10 -> mispredict, ctr=01
    runBranch("t3.nt",    32'h10, 1, 0, 0, 32'h40, 1, 32'h40, 1, 32'h14);
    // 4: taken from ctr=01 predicts not-taken, then climbs to 11
    runBranch("t4.tk1",   32'h10, 1, 0, 1, 32'h40, 0, 32'h14, 1, 32'h40);
    runBranch("t4.tk2",   32'h10, 1, 0, 1, 32'h40, 1, 32'h40, 0, 32'h0);
    runBranch("t4.tk3",   32'h10, 1, 0, 1, 32'h40, 1, 32'h40, 0, 32'h0);
    runBranch("t4.tk4",   32'h10, 1, 0, 1, 32'h40, 1, 32'h40, 0, 32'h0);
    runBranch("t4.nt",    32'h10, 1, 0, 0, 32'h40, 1, 32'h40, 1, 32'h14);
    runBranch("t4.still", 32'h10, 1, 0, 1, 32'h40, 1, 32'h40, 0, 32'h0);
    // jal: allocate, drive ctr to 01 via a not-taken resolution, still predicted
    runBranch("t4.jal1",  32'h20, 0, 1, 1, 32'h80, 0, 32'h24, 1, 32'h80);
    runBranch("t4.jnt",   32'h20, 1, 0, 0, 32'h80, 1, 32'h80, 1, 32'h24);
    runBranch("t4.jal2",  32'h20, 0, 1, 1, 32'h80, 1, 32'h80, 0, 32'h0);

    // 5: alias miss, forged entry on a non-CF instruction, target change
    runBranch("t5.miss",  32'h50, 0, 0, 0, 32'h0,  0, 32'h54, 0, 32'h0);
    runBranch("t5.forge", 32'h30, 1, 0, 1, 32'h90, 0, 32'h34, 1, 32'h90);
    runBranch("t5.alias", 32'h30, 0, 0, 0, 32'h0,  1, 32'h90, 1, 32'h34);
    runBranch("t5.inval", 32'h30, 0, 0, 0, 32'h0,  0, 32'h34, 0, 32'h0);
    runBranch("t5.tgtch", 32'h10, 1, 0, 1, 32'h44, 1, 32'h40, 1, 32'h44);
    runBranch("t5.tgtok", 32'h10, 1, 0, 1, 32'h44, 1, 32'h44, 0, 32'h0);

    // 6a: flush_e removes a would-be mispredict; no table write
    drive(32'h10, 1'b0, 1'b0, 1'b0, 32'h0);
    expectVal("t6f.pred", SIG_PRED, 32'd1);
    expectVal("t6f.next", SIG_NEXT, 32'h44);
    tick();
    drive(F1, 1'b0, 1'b0, 1'b0, 32'h0);
    bpIf.flush_e = 1'b1;
    tick();
    bpIf.flush_e = 1'b0;
    drive(F2, 1'b1, 1'b0, 1'b0, 32'h44);
    expectVal("t6f.mp",   SIG_MP,   32'd0);
    expectVal("t6f.next", SIG_NEXT, F2 + 32'd4);
    tick();
    // ctr must still be 11: one not-taken leaves it predicting taken
    runBranch("t6f.nt",   32'h10, 1, 0, 0, 32'h44, 1, 32'h44, 1, 32'h14);
    runBranch("t6f.tk",   32'h10, 1, 0, 1, 32'h44, 1, 32'h44, 0, 32'h0);

    // 6b: stall_d for 2 cycles (E bubbled), D prediction held, resolves once
    drive(32'h10, 1'b0, 1'b0, 1'b0, 32'h0);
    expectVal("t6s.pred", SIG_PRED, 32'd1);
    tick();
    drive(F1, 1'b0, 1'b0, 1'b0, 32'h0);
    bpIf.stall_d = 1'b1;
    bpIf.flush_e = 1'b1;
    tick();
    drive(F1, 1'b1, 1'b0, 1'b0, 32'h44);
    expectVal("t6s.bub1.mp", SIG_MP, 32'd0);
    tick();
    bpIf.stall_d = 1'b0;
    bpIf.flush_e = 1'b0;
    drive(F2, 1'b1, 1'b0, 1'b0, 32'h44);
    expectVal("t6s.bub2.mp", SIG_MP, 32'd0);
    tick();
    drive(F1, 1'b1, 1'b0, 1'b1, 32'h44);
    expectVal("t6s.res.mp",   SIG_MP,   32'd0);
    expectVal("t6s.res.next", SIG_NEXT, F1 + 32'd4);
    tick();
    brExp++;
    drive(F2, 1'b0, 1'b0, 1'b0, 32'h0);
    expectVal("t6s.after.mp", SIG_MP, 32'd0);
`ifdef BP_STATS_EN
    expectVal("t6.br_count", SIG_BR,  brExp);
    expectVal("t6.mp_count", SIG_MPC, mpExp);
`endif
    tick();

    // Reset mid-operation: pending mispredict vanishes, table is cleared
    drive(32'h10, 1'b0, 1'b0, 1'b0, 32'h0);
    expectVal("rst2.pre.pred", SIG_PRED, 32'd1);
    tick();
    drive(F1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(32'h10, 1'b1, 1'b0, 1'b0, 32'h44);
    rst = 1'b0;
    #1;
    brExp = 0;
    mpExp = 0;
    expectVal("rst2.mp",   SIG_MP,   32'd0);
    expectVal("rst2.pred", SIG_PRED, 32'd0);
    expectVal("rst2.next", SIG_NEXT, 32'h14);
`ifdef BP_STATS_EN
    expectVal("rst2.br", SIG_BR,  32'd0);
    expectVal("rst2.mc", SIG_MPC, 32'd0);
`endif
    tick();
    rst = 1'b1;
    tick();

    $display("[TB] model br=%0d mp=%0d", brExp, mpExp);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end
endmodule
